// File: rtl/bp_recovery_ctrl.sv
// Branch-predictor recovery controller: tracks in-flight branches in order,
// trains the predictor on resolve, and on a mispredict squashes, redirects and repairs history.
module bp_recovery_ctrl #(
    parameter int DEPTH       = 4,
    parameter int GHR_W       = 6,
    parameter int RECOVER_CYC = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enq_valid,
    input  logic             enq_pred_take,
    input  logic [31:0]      enq_alt_pc,
    input  logic [GHR_W-1:0] enq_ghr,
    input  logic             res_valid,
    input  logic             res_take,
    output logic             flush,
    output logic [31:0]      redirect_pc,
    output logic             upd_valid,
    output logic             upd_take,
    output logic [GHR_W-1:0] upd_ghr,
    output logic             ghr_restore_valid,
    output logic [GHR_W-1:0] ghr_restore,
    output logic             full,
    output logic             underflow_err,
    output logic [15:0]      mispred_cnt
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [2:0] TIMER_INIT = 3'(RECOVER_CYC);

    typedef enum logic {RUN, SQUASH} state_t;

    state_t           state;
    logic [2:0]       timer;
    logic [PW-1:0]    head;
    logic [PW-1:0]    tail;
    logic [CW-1:0]    count;
    logic             pred_q [DEPTH];
    logic [31:0]      alt_q  [DEPTH];
    logic [GHR_W-1:0] ghr_q  [DEPTH];

    logic             running;
    logic             deq;
    logic             mispred;
    logic             enq;
    logic [GHR_W-1:0] head_ghr;

    assign full = (count == CW'(DEPTH));

    // An enqueue at full is accepted only when a correct resolve frees the head
    // in the same cycle; a mispredict discards any same-cycle enqueue as wrong-path.
    always_comb begin
        running  = (state == RUN);
        deq      = running & res_valid & (count != '0);
        mispred  = deq & (res_take != pred_q[head]);
        enq      = running & enq_valid & (~full | deq) & ~mispred;
        head_ghr = ghr_q[head];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state             <= RUN;
            timer             <= '0;
            head              <= '0;
            tail              <= '0;
            count             <= '0;
            flush             <= 1'b0;
            redirect_pc       <= '0;
            upd_valid         <= 1'b0;
            upd_take          <= 1'b0;
            upd_ghr           <= '0;
            ghr_restore_valid <= 1'b0;
            ghr_restore       <= '0;
            underflow_err     <= 1'b0;
            mispred_cnt       <= '0;
        end else begin
            flush             <= 1'b0;
            ghr_restore_valid <= 1'b0;
            upd_valid         <= deq;

            if (deq) begin
                upd_take <= res_take;
                upd_ghr  <= head_ghr;
            end

            if (running && res_valid && count == '0)
                underflow_err <= 1'b1;

            if (mispred) begin
                state             <= SQUASH;
                timer             <= TIMER_INIT;
                flush             <= 1'b1;
                redirect_pc       <= alt_q[head];
                ghr_restore_valid <= 1'b1;
                ghr_restore       <= {head_ghr[GHR_W-2:0], res_take};
                if (mispred_cnt != '1)
                    mispred_cnt <= mispred_cnt + 16'd1;
                count <= '0;
                head  <= '0;
                tail  <= '0;
            end else begin
                if (enq) begin
                    pred_q[tail] <= enq_pred_take;
                    alt_q[tail]  <= enq_alt_pc;
                    ghr_q[tail]  <= enq_ghr;
                    tail         <= tail + PW'(1);
                end
                if (deq)
                    head <= head + PW'(1);
                case ({enq, deq})
                    2'b10:   count <= count + CW'(1);
                    2'b01:   count <= count - CW'(1);
                    default: count <= count;
                endcase
            end

            if (state == SQUASH) begin
                timer <= timer - 3'd1;
                if (timer == 3'd1)
                    state <= RUN;
            end
        end
    end

endmodule

// File: tb/tb_bp_recovery_ctrl.sv
// Scoreboard bench for bp_recovery_ctrl: stimulus queues expected predictor
// updates and flushes; a negedge monitor pops and compares whenever they appear.
module tb_bp_recovery_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        enq_valid;
    logic        enq_pred_take;
    logic [31:0] enq_alt_pc;
    logic [5:0]  enq_ghr;
    logic        res_valid;
    logic        res_take;
    logic        flush;
    logic [31:0] redirect_pc;
    logic        upd_valid;
    logic        upd_take;
    logic [5:0]  upd_ghr;
    logic        ghr_restore_valid;
    logic [5:0]  ghr_restore;
    logic        full;
    logic        underflow_err;
    logic [15:0] mispred_cnt;

    int checks = 0;
    int errors = 0;

    logic [6:0]  upd_exp   [$];   // {take, ghr}
    logic [37:0] flush_exp [$];   // {redirect_pc, ghr_restore}
    logic        prev_flush = 1'b0;

    always #5 clk = ~clk;

    bp_recovery_ctrl #(.DEPTH(4), .GHR_W(6), .RECOVER_CYC(2)) dut (
        .clk(clk), .rst(rst),
        .enq_valid(enq_valid), .enq_pred_take(enq_pred_take),
        .enq_alt_pc(enq_alt_pc), .enq_ghr(enq_ghr),
        .res_valid(res_valid), .res_take(res_take),
        .flush(flush), .redirect_pc(redirect_pc),
        .upd_valid(upd_valid), .upd_take(upd_take), .upd_ghr(upd_ghr),
        .ghr_restore_valid(ghr_restore_valid), .ghr_restore(ghr_restore),
        .full(full), .underflow_err(underflow_err), .mispred_cnt(mispred_cnt)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every update/flush the DUT presents must match the next queued expectation.
    always @(negedge clk) begin
        if (upd_valid) begin
            checks++;
            if (upd_exp.size() == 0) begin
                errors++;
                $display("FAIL upd_unexpected: got take=%0d ghr=0x%0h expected no update", upd_take, upd_ghr);
            end else begin
                logic [6:0] e;
                e = upd_exp.pop_front();
                if ({upd_take, upd_ghr} !== e) begin
                    errors++;
                    $display("FAIL upd: got 0x%0h expected 0x%0h", {upd_take, upd_ghr}, e);
                end
            end
        end
        if (flush) begin
            checks++;
            if (flush_exp.size() == 0) begin
                errors++;
                $display("FAIL flush_unexpected: got pc=0x%0h expected no flush", redirect_pc);
            end else begin
                logic [37:0] e;
                e = flush_exp.pop_front();
                if ({ghr_restore_valid, redirect_pc, ghr_restore} !== {1'b1, e}) begin
                    errors++;
                    $display("FAIL flush: got 0x%0h expected 0x%0h",
                             {ghr_restore_valid, redirect_pc, ghr_restore}, {1'b1, e});
                end
            end
            if (prev_flush) begin
                checks++;
                errors++;
                $display("FAIL flush_pulse: got 1 in consecutive cycles expected single pulse");
            end
        end
        if (ghr_restore_valid !== flush) begin
            checks++;
            errors++;
            $display("FAIL restore_vs_flush: got %0d expected %0d", ghr_restore_valid, flush);
        end
        prev_flush = flush;
    end

    task automatic cyc(input logic e, input logic pt, input logic [31:0] alt,
                       input logic [5:0] g, input logic r, input logic rt);
        enq_valid     = e;
        enq_pred_take = pt;
        enq_alt_pc    = alt;
        enq_ghr       = g;
        res_valid     = r;
        res_take      = rt;
        @(posedge clk);
        #1;
        enq_valid = 1'b0;
        res_valid = 1'b0;
    endtask

    task automatic enq_only(input logic pt, input logic [31:0] alt, input logic [5:0] g);
        cyc(1'b1, pt, alt, g, 1'b0, 1'b0);
    endtask

    task automatic res_only(input logic rt);
        cyc(1'b0, 1'b0, 32'h0, 6'h0, 1'b1, rt);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 32'h0, 6'h0, 1'b0, 1'b0);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_flush"},     64'(flush), 64'h0);
        check({tag, "_upd_valid"}, 64'(upd_valid), 64'h0);
        check({tag, "_restore_v"}, 64'(ghr_restore_valid), 64'h0);
        check({tag, "_full"},      64'(full), 64'h0);
        check({tag, "_underflow"}, 64'(underflow_err), 64'h0);
        check({tag, "_cnt"},       64'(mispred_cnt), 64'h0);
        check({tag, "_redirect"},  64'(redirect_pc), 64'h0);
    endtask

    initial begin
        rst = 1'b1;
        enq_valid = 1'b0; enq_pred_take = 1'b0; enq_alt_pc = '0; enq_ghr = '0;
        res_valid = 1'b0; res_take = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check_reset_vals("reset");
        rst = 1'b0;

        // Correct prediction trains without flushing.
        enq_only(1'b1, 32'h100, 6'h05);
        upd_exp.push_back({1'b1, 6'h05});
        res_only(1'b1);
        idle(1);

        // Mispredict with a same-cycle enqueue, then enqueues during squash: all wrong-path.
        enq_only(1'b0, 32'h2000, 6'h2A);
        upd_exp.push_back({1'b1, 6'h2A});
        flush_exp.push_back({32'h2000, 6'h15});
        cyc(1'b1, 1'b1, 32'hDEAD, 6'h03, 1'b1, 1'b1);
        check("mispred_cnt_1", 64'(mispred_cnt), 64'd1);
        cyc(1'b1, 1'b1, 32'hBEEF, 6'h04, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 32'hCAFE, 6'h06, 1'b0, 1'b0);
        // Queue must be empty now: resolve gives underflow and no update.
        res_only(1'b1);
        check("underflow_set", 64'(underflow_err), 64'h1);
        idle(3);
        check("underflow_held", 64'(underflow_err), 64'h1);

        // Fill, simultaneous enq+correct resolve at full, dropped enq at full, ordered drain.
        enq_only(1'b1, 32'h10, 6'h01);
        enq_only(1'b0, 32'h20, 6'h02);
        enq_only(1'b1, 32'h30, 6'h03);
        check("not_full_3", 64'(full), 64'h0);
        enq_only(1'b0, 32'h40, 6'h04);
        check("full_4", 64'(full), 64'h1);
        upd_exp.push_back({1'b1, 6'h01});
        cyc(1'b1, 1'b1, 32'h50, 6'h05, 1'b1, 1'b1);
        check("full_after_enq_deq", 64'(full), 64'h1);
        enq_only(1'b1, 32'h60, 6'h06);
        check("full_after_drop", 64'(full), 64'h1);
        upd_exp.push_back({1'b0, 6'h02});
        res_only(1'b0);
        check("not_full_after_deq", 64'(full), 64'h0);
        upd_exp.push_back({1'b1, 6'h03});
        res_only(1'b1);
        upd_exp.push_back({1'b0, 6'h04});
        res_only(1'b0);
        upd_exp.push_back({1'b1, 6'h05});
        res_only(1'b1);
        res_only(1'b1);
        idle(2);
        check("cnt_after_drain", 64'(mispred_cnt), 64'd1);

        // Reset during squash.
        enq_only(1'b0, 32'h500, 6'h07);
        upd_exp.push_back({1'b1, 6'h07});
        flush_exp.push_back({32'h500, 6'h0F});
        res_only(1'b1);
        rst = 1'b1;
        @(posedge clk); #1;
        check_reset_vals("rst_squash");
        rst = 1'b0;
        enq_only(1'b1, 32'h600, 6'h11);
        upd_exp.push_back({1'b1, 6'h11});
        res_only(1'b1);
        idle(1);

        // Back-to-back mispredicts: the second resolve lands in squash and is ignored.
        enq_only(1'b1, 32'h300, 6'h3F);
        enq_only(1'b1, 32'h400, 6'h01);
        upd_exp.push_back({1'b0, 6'h3F});
        flush_exp.push_back({32'h300, 6'h3E});
        res_only(1'b0);
        res_only(1'b0);
        idle(2);
        check("cnt_b2b", 64'(mispred_cnt), 64'd1);
        res_only(1'b1);
        idle(3);

        check("upd_exp_drained", 64'(upd_exp.size()), 64'd0);
        check("flush_exp_drained", 64'(flush_exp.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
